// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream sources.
// Ownership is message-atomic and assigned round-robin. An owner that withholds
// data for TIMEOUT_CYCLES ready cycles is evicted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; arbitrate among req_valid starting after last_owner
//   SEND    | owner may transfer one byte when the transmitter is not busy
//   GAP     | two dead cycles after a byte so tx_busy has time to assert
//   RELEASE | last byte sent; drop grant, remember owner, return to IDLE
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    output logic                 timeout_evt
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_GAP     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_owner_q, last_owner_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_data_q, new_tx_data_d;
    logic               timeout_evt_q, timeout_evt_d;
    logic               gap_q, gap_d;
    logic [CW-1:0]      tout_cnt_q, tout_cnt_d;

    logic               arb_found;
    logic [IW-1:0]      arb_idx;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;

    // Round-robin pick: first requester found searching upward from last_owner+1, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_owner_q) + i) % NUM_REQ;
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
    end

    // Select the current owner's request signals.
    always_comb begin
        owner_valid = req_valid[owner_q];
        owner_last  = req_last[owner_q];
        owner_data  = req_data[{owner_q, 3'b000} +: 8];
    end

    // Only the owner may see ready, and only while SEND and the transmitter is free.
    always_comb begin
        req_ready = '0;
        if (state_q == S_SEND) begin
            req_ready[owner_q] = !tx_busy;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        timeout_evt_d = 1'b0;
        gap_d         = gap_q;
        tout_cnt_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    owner_d = arb_idx;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_busy) begin
                    // A transmitter stall does not count against the owner.
                    tout_cnt_d = tout_cnt_q;
                end else if (owner_valid) begin
                    tx_data_d     = owner_data;
                    new_tx_data_d = 1'b1;
                    gap_d         = 1'b0;
                    state_d       = owner_last ? S_RELEASE : S_GAP;
                end else if (tout_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Evict; the partial message is left unterminated.
                    timeout_evt_d = 1'b1;
                    last_owner_d  = owner_q;
                    grant_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    tout_cnt_d = tout_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                gap_d = 1'b1;
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = S_SEND;
                end
            end

            S_RELEASE: begin
                last_owner_d = owner_q;
                grant_d      = '0;
                state_d      = S_IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            last_owner_q  <= IW'(NUM_REQ - 1);
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            timeout_evt_q <= 1'b0;
            gap_q         <= 1'b0;
            tout_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            timeout_evt_q <= timeout_evt_d;
            gap_q         <= gap_d;
            tout_cnt_q    <= tout_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign timeout_evt = timeout_evt_q;

endmodule
